symbol_deserializer: RTL

//  Serial receive front-end of the text link. Recovers framed 7-bit symbol codes from the

---
 rtl/text_link_pkg.sv | 23 ++
 rtl/sym_fifo.sv | 56 +++++
 rtl/symbol_deserializer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/text_link_pkg.sv
// Shared definitions for the text-link receive path: symbol width, receiver states
// and the parity helper used by the deserializer.
package text_link_pkg;

  localparam int SYM_W = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b1;

  // Parity bit that makes d plus the bit an even number of ones.
  function automatic logic even_par(input logic [SYM_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Show-ahead symbol FIFO. The level is held explicitly (0..DEPTH) and a push
// while full is accepted only when a pop happens on the same edge.
module sym_fifo
  import text_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = SYM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     push_rej
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic          pop_eff, push_ok;

  assign empty    = (level_q == '0);
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_ok  = push && (!full || pop_eff);
  assign push_rej = push && !push_ok;
  assign level    = level_q;
  assign dout     = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_eff) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_eff})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/symbol_deserializer.sv
// Serial receive front-end: synchronizes rx_bit, recovers start/7 data/parity/stop
// frames at mid-bit, flags parity and framing errors, and buffers good codes.
module symbol_deserializer
  import text_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_bit,
  output logic [SYM_W-1:0]              out_code,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_t        state_q, state_d;
  logic             rx_m_q, rx_s_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SYM_W-1:0] shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic             par_ok_q, par_ok_d;
  logic             pe_q, pe_d, fe_q, fe_d, ov_q;
  logic             push, push_rej, fifo_full, fifo_empty;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    shift_d  = shift_q;
    bit_d    = bit_q;
    par_ok_d = par_ok_q;
    push     = 1'b0;
    pe_d     = 1'b0;
    fe_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // After the half-bit wait, counting a full bit lands on each bit centre.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[SYM_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd6) state_d = PARITY;
        end
      end
      PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d    = '0;
          par_ok_d = ((even_par(shift_q) ^ rx_s_q) == 1'b0) ? PARITY_EVEN : ~PARITY_EVEN;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            fe_d    = 1'b1;
            pe_d    = (par_ok_q != PARITY_EVEN);
            state_d = WAIT_HIGH;
          end else if (par_ok_q != PARITY_EVEN) begin
            pe_d    = 1'b1;
            state_d = IDLE;
          end else begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      par_ok_q <= PARITY_EVEN;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      rx_m_q   <= rx_bit;
      rx_s_q   <= rx_m_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      par_ok_q <= par_ok_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      ov_q     <= push_rej;
    end
  end

  sym_fifo #(.DEPTH(FIFO_DEPTH), .W(SYM_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (shift_q),
    .pop      (out_ready),
    .dout     (out_code),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .push_rej (push_rej)
  );

  assign out_valid  = !fifo_empty;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overflow   = ov_q;

endmodule
